core_seq: RTL

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq_pkg.sv | 24 ++
 rtl/core_seq_req.sv | 28 ++
 rtl/core_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/core_seq_pkg.sv
// Shared definitions for the core sequencer: FSM state encoding, trap causes, reset instruction.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_TRAP  = 3'd4
    } state_t;

    localparam int unsigned CAUSE_W = 2;

    typedef logic [CAUSE_W-1:0] cause_t;

    localparam cause_t CAUSE_NONE    = 2'b00;
    localparam cause_t CAUSE_IFETCH  = 2'b01;
    localparam cause_t CAUSE_DMEM    = 2'b10;
    localparam cause_t CAUSE_TIMEOUT = 2'b11;

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/core_seq_req.sv
// Wait-cycle counter shared by the FETCH and MEM request phases.
module req_timer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expired_c
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (active) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // Last permitted wait cycle: with no response now the request gives up.
    assign expired_c = active && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: fetch, execute, optional data access, trap entry.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic            imem_err,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst_q,
    input  logic            dec_mem_en,
    output logic            dmem_req,
    input  logic            dmem_ack,
    input  logic            dmem_err,
    output logic            commit,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [XLEN-1:0] retire_cnt
);

    state_t state;
    state_t state_next;
    cause_t cause_next;
    logic   inst_load_c;
    logic   commit_c;
    logic   timer_clear_c;
    logic   timer_active_c;
    logic   expired_c;

    req_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_req_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear_c),
        .active    (timer_active_c),
        .expired_c (expired_c)
    );

    // Any state change clears the timer, so every FETCH/MEM entry starts from zero.
    assign timer_clear_c  = (state_next != state);
    assign timer_active_c = (state == ST_FETCH) || (state == ST_MEM);

    // Next-state and same-cycle commit decode; err beats ack, ack beats timeout.
    always_comb begin
        state_next  = state;
        cause_next  = CAUSE_NONE;
        inst_load_c = 1'b0;
        commit_c    = 1'b0;
        case (state)
            ST_BOOT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_err) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_IFETCH;
                end else if (imem_ack) begin
                    state_next  = ST_EXEC;
                    inst_load_c = 1'b1;
                end else if (expired_c) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_EXEC: begin
                if (dec_mem_en) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_FETCH;
                    commit_c   = 1'b1;
                end
            end
            ST_MEM: begin
                if (dmem_err) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_DMEM;
                end else if (dmem_ack) begin
                    state_next = ST_FETCH;
                    commit_c   = 1'b1;
                end else if (expired_c) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_TRAP: begin
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    assign commit = commit_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Request and trap strobes are registered copies of the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            imem_req   <= (state_next == ST_FETCH);
            dmem_req   <= (state_next == ST_MEM);
            trap       <= (state_next == ST_TRAP);
            trap_cause <= cause_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_addr <= '0;
        end else if ((state_next == ST_FETCH) && (state != ST_FETCH)) begin
            imem_addr <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q <= NOP_INST;
        end else if (inst_load_c) begin
            inst_q <= imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (commit_c) begin
            retire_cnt <= retire_cnt + XLEN'(1);
        end
    end

endmodule
